// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared MIPS32 opcodes, instruction types and fetch-queue entry
package mips32_pkg;

   localparam int IMEM_AW = 10;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   typedef enum logic [2:0] {
      IT_RR_ALU,
      IT_RM_ALU,
      IT_LOAD,
      IT_STORE,
      IT_BRANCH,
      IT_HALT,
      IT_UNKNOWN
   } instr_type_t;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] npc;
   } fetch_entry_t;

   typedef enum logic {
      FS_RUN,
      FS_STOP
   } fetch_state_t;

   function automatic instr_type_t decode_type(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: decode_type = IT_RR_ALU;
         OP_ADDI, OP_SUBI, OP_SLTI:                    decode_type = IT_RM_ALU;
         OP_LW:                                        decode_type = IT_LOAD;
         OP_SW:                                        decode_type = IT_STORE;
         OP_BNEQZ, OP_BEQZ:                            decode_type = IT_BRANCH;
         OP_HLT:                                       decode_type = IT_HALT;
         default:                                      decode_type = IT_UNKNOWN;
      endcase
   endfunction

endpackage

// File: rtl/mips32_ifq_fifo.sv
// rtl/mips32_ifq_fifo.sv - synchronous fetch-entry FIFO with flush, count and head view
module mips32_ifq_fifo
   import mips32_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output logic [CW-1:0] count,
   output fetch_entry_t head
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t      mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/mips32_instr_prefetch.sv
// rtl/mips32_instr_prefetch.sv - instruction prefetch unit ahead of the IF/ID boundary
// HLT detection and the STOP state exist only when PREFETCH_HALT_STOP_EN is defined.
module mips32_instr_prefetch
   import mips32_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          imem_req_o,
   output logic [AW-1:0] imem_addr_o,
   input  logic [31:0]   imem_rdata_i,
   input  logic          redirect_i,
   input  logic [AW-1:0] redirect_pc_i,
   output logic          dec_valid_o,
   input  logic          dec_ready_i,
   output logic [31:0]   dec_ir_o,
   output logic [31:0]   dec_npc_o,
   output logic          fetch_stopped_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [AW-1:0] pc;
   logic [AW-1:0] inflight_addr;
   logic          inflight;
   logic          drop;
   fetch_state_t  state;

   logic [CW-1:0] count;
   logic [CW:0]   used;
   logic          credit_ok;
   logic          running;
   logic          issue;
   logic          ret_ok;
   logic          pop;
   fetch_entry_t  push_entry;
   fetch_entry_t  head;

   // Credit counts the outstanding return so a push can never overflow.
   assign used      = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign credit_ok = used < DEPTH_C;

`ifdef PREFETCH_HALT_STOP_EN
   assign running = (state == FS_RUN);
`else
   assign running = 1'b1;
`endif

   assign issue       = rst_n & running & ~redirect_i & credit_ok;
   assign imem_req_o  = issue;
   assign imem_addr_o = pc;

   // A return landing in a redirect cycle is discarded by the flush itself.
   assign ret_ok          = inflight & ~drop & ~redirect_i;
   assign push_entry.ir   = imem_rdata_i;
   assign push_entry.npc  = {{(32-AW){1'b0}}, inflight_addr} + 32'd1;

   assign dec_valid_o = (count != '0) & ~redirect_i;
   assign pop         = dec_valid_o & dec_ready_i;

   mips32_ifq_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_i),
      .push      (ret_ok),
      .push_data (push_entry),
      .pop       (pop),
      .count     (count),
      .head      (head)
   );

   assign dec_ir_o  = head.ir;
   assign dec_npc_o = head.npc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc            <= '0;
         inflight      <= 1'b0;
         inflight_addr <= '0;
         drop          <= 1'b0;
      end else begin
         if (redirect_i)  pc <= redirect_pc_i;
         else if (issue)  pc <= pc + AW'(1);
         inflight <= issue;
         if (issue) inflight_addr <= pc;
         if (redirect_i)             drop <= issue;
         else if (inflight && drop)  drop <= 1'b0;
      end
   end

`ifdef PREFETCH_HALT_STOP_EN
   logic hlt_ret;
   assign hlt_ret = ret_ok & (imem_rdata_i[31:26] == OP_HLT);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= FS_RUN;
`ifdef PREFETCH_HALT_STOP_EN
      end else if (redirect_i) begin
         state <= FS_RUN;
      end else if (hlt_ret) begin
         state <= FS_STOP;
`endif
      end
   end

   assign fetch_stopped_o = (state == FS_STOP);

endmodule
